// File: rtl/basic_types_pkg.sv
// Core-wide scalar types shared by the pipeline and the memory port.
package BasicTypes;

  typedef logic [31:0] PC;
  typedef logic [31:0] BasicData;

endpackage

// File: rtl/mem_port_arbiter_pkg.sv
// Types for the shared memory port: access widths, arbiter states and byte-enable vectors.
package MemoryTypes;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } MemAccessWidth;

  typedef enum logic [1:0] {
    IDLE,
    BUS_IF,
    BUS_MA,
    RESP
  } MemArbState;

  typedef logic [3:0] ByteEnable;

endpackage

// File: rtl/mem_port_arbiter_byte_lane_gen.sv
// Combinational lane steering for MA accesses: byte enables, replicated store data and
// alignment check from the access width and the low address bits.
module byte_lane_gen
  import BasicTypes::*;
  import MemoryTypes::*;
(
  input  MemAccessWidth width,
  input  logic [1:0]    offset,
  input  BasicData      wdata,
  output ByteEnable     byteEn,
  output BasicData      laneData,
  output logic          misaligned
);

  always_comb begin
    byteEn     = 4'b1111;
    laneData   = wdata;
    misaligned = 1'b0;
    case (width)
      MEM_BYTE: begin
        byteEn   = 4'b0001 << offset;
        laneData = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        byteEn     = 4'b0011 << offset;
        laneData   = {2{wdata[15:0]}};
        misaligned = offset[0];
      end
      // MEM_WORD and the unused encoding 3 both behave as a full word.
      default: misaligned = |offset;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and the memory-access
// stage; all outputs are registered.
module mem_port_arbiter
  import BasicTypes::*;
  import MemoryTypes::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifReq,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  input  logic                  ifKill,
  output logic [DATA_WIDTH-1:0] ifRdata,
  output logic                  ifDone,
  input  logic                  maReq,
  input  logic                  maWe,
  input  logic [ADDR_WIDTH-1:0] maAddr,
  input  logic [DATA_WIDTH-1:0] maWdata,
  input  logic [1:0]            maWidth,
  output logic [DATA_WIDTH-1:0] maRdata,
  output logic                  maDone,
  output logic                  maMisaligned,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  output logic [3:0]            memByteEn,
  input  logic [DATA_WIDTH-1:0] memRdata,
  input  logic                  memAck
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] starveMax = CntW'(STARVE_LIMIT);

  MemArbState state, stateD;
  logic [CntW-1:0] starveCnt, starveCntD;
  logic killed, killedD;

  logic memReqD, memWeD, ifDoneD, maDoneD, maMisalignedD;
  logic [ADDR_WIDTH-1:0] memAddrD;
  logic [DATA_WIDTH-1:0] memWdataD, ifRdataD, maRdataD;
  logic [3:0] memByteEnD;

  ByteEnable laneByteEn;
  BasicData  laneWdata;
  logic      laneMisaligned;
  logic      ifGrant;

  byte_lane_gen uLaneGen (
    .width     (MemAccessWidth'(maWidth)),
    .offset    (maAddr[1:0]),
    .wdata     (maWdata),
    .byteEn    (laneByteEn),
    .laneData  (laneWdata),
    .misaligned(laneMisaligned)
  );

  assign ifGrant = ifReq && !ifKill && (!maReq || starveCnt == starveMax);

  always_comb begin
    stateD        = state;
    starveCntD    = starveCnt;
    killedD       = killed;
    memReqD       = memReq;
    memWeD        = memWe;
    memAddrD      = memAddr;
    memWdataD     = memWdata;
    memByteEnD    = memByteEn;
    ifRdataD      = ifRdata;
    maRdataD      = maRdata;
    ifDoneD       = 1'b0;
    maDoneD       = 1'b0;
    maMisalignedD = 1'b0;

    if (!ifReq) starveCntD = '0;

    case (state)
      IDLE: begin
        if (ifGrant) begin
          stateD     = BUS_IF;
          starveCntD = '0;
          memReqD    = 1'b1;
          memWeD     = 1'b0;
          memByteEnD = 4'b1111;
          memAddrD   = {ifAddr[ADDR_WIDTH-1:2], 2'b00};
        end else if (maReq) begin
          if (ifReq && starveCnt != starveMax) starveCntD = starveCnt + CntW'(1);
          if (laneMisaligned) begin
            // Rejected without touching the bus.
            stateD        = RESP;
            maDoneD       = 1'b1;
            maMisalignedD = 1'b1;
          end else begin
            stateD     = BUS_MA;
            memReqD    = 1'b1;
            memWeD     = maWe;
            memByteEnD = laneByteEn;
            memWdataD  = laneWdata;
            memAddrD   = {maAddr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end
      BUS_IF: begin
        if (ifKill) killedD = 1'b1;
        if (memAck) begin
          stateD   = RESP;
          memReqD  = 1'b0;
          ifRdataD = memRdata;
          ifDoneD  = !(killed || ifKill);
        end
      end
      BUS_MA: begin
        if (memAck) begin
          stateD   = RESP;
          memReqD  = 1'b0;
          maRdataD = memRdata;
          maDoneD  = 1'b1;
        end
      end
      RESP: begin
        stateD  = IDLE;
        killedD = 1'b0;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      starveCnt    <= '0;
      killed       <= 1'b0;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWdata     <= '0;
      memByteEn    <= '0;
      ifRdata      <= '0;
      maRdata      <= '0;
      ifDone       <= 1'b0;
      maDone       <= 1'b0;
      maMisaligned <= 1'b0;
    end else begin
      state        <= stateD;
      starveCnt    <= starveCntD;
      killed       <= killedD;
      memReq       <= memReqD;
      memWe        <= memWeD;
      memAddr      <= memAddrD;
      memWdata     <= memWdataD;
      memByteEn    <= memByteEnD;
      ifRdata      <= ifRdataD;
      maRdata      <= maRdataD;
      ifDone       <= ifDoneD;
      maDone       <= maDoneD;
      maMisaligned <= maMisalignedD;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle, plus
// literal expectations for each scenario.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ifReq = 1'b0, ifKill = 1'b0, maReq = 1'b0, maWe = 1'b0, memAck = 1'b0;
  logic [31:0] ifAddr = '0, maAddr = '0, maWdata = '0, memRdata = '0;
  logic [1:0] maWidth = '0;
  logic [31:0] ifRdata, maRdata, memAddr, memWdata;
  logic ifDone, maDone, maMisaligned, memReq, memWe;
  logic [3:0] memByteEn;

  mem_port_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifReq       (ifReq),
    .ifAddr      (ifAddr),
    .ifKill      (ifKill),
    .ifRdata     (ifRdata),
    .ifDone      (ifDone),
    .maReq       (maReq),
    .maWe        (maWe),
    .maAddr      (maAddr),
    .maWdata     (maWdata),
    .maWidth     (maWidth),
    .maRdata     (maRdata),
    .maDone      (maDone),
    .maMisaligned(maMisaligned),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWdata    (memWdata),
    .memByteEn   (memByteEn),
    .memRdata    (memRdata),
    .memAck      (memAck)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bus responder ----------------
  int ackLat = 0;
  bit forceAck = 0;
  logic [31:0] rdataVal = '0;
  int seen = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (forceAck) begin
      memAck = 1'b1;
    end else if (memReq) begin
      if (seen == ackLat) begin
        memAck   = 1'b1;
        memRdata = rdataVal;
      end else begin
        memAck   = 1'b0;
        memRdata = ~rdataVal;
      end
      seen++;
    end else begin
      memAck   = 1'b0;
      memRdata = ~rdataVal;
      seen     = 0;
    end
  end

  // ---------------- transaction-level model ----------------
  function automatic int accSize(input logic [1:0] w);
    return (w == 2'd0) ? 1 : ((w == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [3:0] beOf(input logic [1:0] w, input logic [31:0] a);
    int sz = accSize(w);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] wdOf(input logic [1:0] w, input logic [31:0] d);
    int sz = accSize(w);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  logic eMemReq = 0, eMemWe = 0, eIfDone = 0, eMaDone = 0, eMis = 0;
  logic [31:0] eAddr = '0, eWdata = '0, eIfRdata = '0, eMaRdata = '0;
  logic [3:0] eBe = '0;
  int owner = -1;  // -1 bus free, 0 fetch, 1 memory access
  bit respCycle = 0, mKilled = 0;
  int starve = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      eMemReq = 0; eMemWe = 0; eIfDone = 0; eMaDone = 0; eMis = 0;
      owner = -1; respCycle = 0; mKilled = 0; starve = 0;
    end else begin
      if (!ifReq) starve = 0;
      eIfDone = 0; eMaDone = 0; eMis = 0;
      if (respCycle) begin
        respCycle = 0;
        mKilled   = 0;
      end else if (owner == -1) begin
        if (ifReq && !ifKill && (!maReq || starve == LIMIT)) begin
          owner = 0; starve = 0;
          eMemReq = 1; eMemWe = 0; eBe = 4'hF; eAddr = ifAddr & ~32'd3;
        end else if (maReq) begin
          if (ifReq && starve < LIMIT) starve++;
          if ((maAddr % accSize(maWidth)) != 0) begin
            respCycle = 1; eMaDone = 1; eMis = 1;
          end else begin
            owner = 1;
            eMemReq = 1; eMemWe = maWe; eAddr = maAddr & ~32'd3;
            eBe = beOf(maWidth, maAddr); eWdata = wdOf(maWidth, maWdata);
          end
        end
      end else begin
        if (owner == 0 && ifKill) mKilled = 1;
        if (memAck) begin
          eMemReq = 0;
          if (owner == 0) begin eIfDone = !mKilled; eIfRdata = memRdata; end
          else begin eMaDone = 1; eMaRdata = memRdata; end
          owner = -1; respCycle = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int ifDoneCnt = 0, maDoneCnt = 0, reqCycles = 0;
  logic [31:0] lastAddr = '0, lastWdata = '0;
  logic [3:0] lastBe = '0;
  logic lastWe = 0;

  initial forever begin
    @(negedge clk);
    check("memReq", memReq, eMemReq);
    if (eMemReq) begin
      check("memWe", memWe, eMemWe);
      check("memAddr", memAddr, eAddr);
      check("memByteEn", memByteEn, eBe);
      if (eMemWe) check("memWdata", memWdata, eWdata);
    end
    check("ifDone", ifDone, eIfDone);
    check("maDone", maDone, eMaDone);
    check("maMisaligned", maMisaligned, eMis);
    if (eIfDone) check("ifRdata", ifRdata, eIfRdata);
    if (eMaDone && !eMis) check("maRdata", maRdata, eMaRdata);
    if (ifDone) ifDoneCnt++;
    if (maDone) maDoneCnt++;
    if (memReq) begin
      reqCycles++;
      lastAddr = memAddr; lastBe = memByteEn; lastWe = memWe; lastWdata = memWdata;
    end
  end

  // ---------------- requester tasks ----------------
  int lastLat;
  logic [31:0] lastRdata;
  logic lastMis;

  task automatic waitDone(input bit isIf, input string name);
    bit ok = 0;
    int n = 0;
    int start = cyc;
    while (n < 60 && !ok) begin
      @(negedge clk);
      if (isIf ? ifDone : maDone) begin
        ok = 1;
        lastRdata = isIf ? ifRdata : maRdata;
        lastMis = maMisaligned;
      end
      n++;
    end
    lastLat = cyc - start;
    check({name, " done seen"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic doIf(input logic [31:0] a, input logic [31:0] rd, input int lat, input string name);
    ackLat = lat; rdataVal = rd; reqCycles = 0;
    ifReq = 1; ifAddr = a;
    waitDone(1, name);
    ifReq = 0;
  endtask

  task automatic doMa(input logic we, input logic [31:0] a, input logic [1:0] w,
                      input logic [31:0] wd, input logic [31:0] rd, input int lat,
                      input string name);
    ackLat = lat; rdataVal = rd; reqCycles = 0;
    maReq = 1; maWe = we; maAddr = a; maWidth = w; maWdata = wd;
    waitDone(0, name);
    maReq = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int expOrder[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int order[$];

  initial begin
    int snap, n;
    bit ok;
    #1 rst = 1;
    @(posedge clk);
    #1;
    check("reset memReq", memReq, 0);
    check("reset memByteEn", memByteEn, 0);
    check("reset done", {ifDone, maDone, maMisaligned}, 0);
    @(posedge clk);
    #1 rst = 0;
    idle(1);

    // Fetch with zero-latency ack
    doIf(32'h100, 32'h13, 0, "if0");
    check("if0 latency", lastLat, 2);
    check("if0 rdata", lastRdata, 32'h13);
    check("if0 addr", lastAddr, 32'h100);
    check("if0 be", lastBe, 4'hF);
    check("if0 we", lastWe, 0);
    idle(1);

    // Byte store with a three-cycle bus request
    snap = maDoneCnt;
    doMa(1, 32'h203, 2'd0, 32'hAB, 32'h0, 2, "sb");
    idle(3);
    check("sb addr", lastAddr, 32'h200);
    check("sb be", lastBe, 4'b1000);
    check("sb wdata", lastWdata, 32'hABABABAB);
    check("sb req cycles", reqCycles, 3);
    check("sb done pulses", maDoneCnt - snap, 1);
    check("sb misaligned", lastMis, 0);

    // Misaligned half store never reaches the bus
    doMa(1, 32'h201, 2'd1, 32'h1234, 32'h0, 0, "sh mis");
    check("sh mis flag", lastMis, 1);
    check("sh mis req cycles", reqCycles, 0);
    idle(1);

    // Aligned half store and word load
    doMa(1, 32'h202, 2'd1, 32'hFFFF5A5A, 32'h0, 1, "sh");
    check("sh be", lastBe, 4'b1100);
    check("sh wdata", lastWdata, 32'h5A5A5A5A);
    doMa(0, 32'h204, 2'd2, 32'h0, 32'hCAFEF00D, 1, "lw");
    check("lw misaligned", lastMis, 0);
    check("lw rdata", lastRdata, 32'hCAFEF00D);
    check("lw addr", lastAddr, 32'h204);
    doMa(0, 32'h208, 2'd3, 32'h0, 32'h600DD00D, 0, "lw3");
    check("lw3 be", lastBe, 4'hF);
    check("lw3 rdata", lastRdata, 32'h600DD00D);
    idle(1);

    // Starvation limit with both requesters held
    ackLat = 0; rdataVal = 32'h11223344;
    maWe = 0; maAddr = 32'h400; maWidth = 2'd2; ifAddr = 32'h104;
    ifReq = 1; maReq = 1;
    n = 0;
    while (order.size() < 10 && n < 200) begin
      @(negedge clk);
      if (ifDone) order.push_back(0);
      if (maDone) order.push_back(1);
      n++;
    end
    @(posedge clk);
    #1;
    ifReq = 0; maReq = 0;
    check("starve done count", order.size(), 10);
    for (int i = 0; i < 10 && i < order.size(); i++)
      check($sformatf("grant order[%0d]", i), order[i], expOrder[i]);
    idle(2);

    // Fetch killed mid-transaction
    snap = ifDoneCnt;
    ackLat = 2; rdataVal = 32'hDEAD0001;
    ifReq = 1; ifAddr = 32'h280;
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = memReq;
      n++;
    end
    check("kill memReq seen", 32'(ok), 1);
    @(posedge clk);
    #1 ifKill = 1; ifReq = 0;
    @(posedge clk);
    #1 ifKill = 0;
    idle(6);
    check("kill no ifDone", ifDoneCnt - snap, 0);
    check("kill bus idle", memReq, 0);
    doIf(32'h300, 32'h00000093, 0, "if after kill");
    check("if after kill rdata", lastRdata, 32'h93);
    check("if after kill addr", lastAddr, 32'h300);
    idle(1);

    // Reset while a load is on the bus, then a stray ack
    snap = ifDoneCnt + maDoneCnt;
    ackLat = 20;
    maReq = 1; maWe = 0; maAddr = 32'h500; maWidth = 2'd2;
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = memReq;
      n++;
    end
    check("rst memReq seen", 32'(ok), 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst drops memReq", memReq, 0);
    maReq = 0;
    @(posedge clk);
    #1 rst = 0;
    #1 forceAck = 1;
    @(posedge clk);
    #2 forceAck = 0;
    idle(4);
    check("rst no done", ifDoneCnt + maDoneCnt - snap, 0);
    check("rst late ack ignored", memReq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
